// File: rtl/shift_pkg.sv
// Shared definitions for the two-requester serial shift scheduler.
package shift_pkg;

  // Frame width; fixed at 8 in this revision.
  localparam int unsigned SHIFT_NBITS = 8;

  // Default system clocks per serial bit (even, >= 2).
  localparam int unsigned SHIFT_CLK_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright; under
// contention the requester that was not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win,
  output logic valid
);

  // Pure combinational pick; the caller registers the result.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      win = ~last;
    end else begin
      win = req1;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Serial shift scheduler: arbitrates two byte requesters and shifts the
// winner's byte out LSB first with a divided shift clock and a latch strobe.
module shift_sched
  import shift_pkg::*;
#(
  parameter int unsigned CLK_DIV = SHIFT_CLK_DIV_DEF,
  parameter int unsigned NBITS   = SHIFT_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [NBITS-1:0] data0,
  input  logic             req1,
  input  logic [NBITS-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy,
  output logic             owner
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             owner_d;
  logic             last_q, last_d;
  logic             gnt0_d, gnt1_d;
  logic             sdata_d, sclk_d, latch_d, busy_d;
  logic             arb_win, arb_valid;

  rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .win   (arb_win),
    .valid (arb_valid)
  );

  // Next-state, datapath and output decode; outputs derive from the next
  // state so every port is a flop that matches the state it is paired with.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    owner_d = owner;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          shreg_d = arb_win ? data1 : data0;
          owner_d = arb_win;
          last_d  = arb_win;
          gnt0_d  = ~arb_win;
          gnt1_d  = arb_win;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = {1'b0, shreg_q[NBITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sdata_d = (state_d == ST_SHIFT) & shreg_d[0];
    sclk_d  = (state_d == ST_SHIFT) && (div_d >= DIV_HALF);
    latch_d = (state_d == ST_LATCH);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset leaves requester 0 favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= 1'b1;
      owner   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sdata   <= 1'b0;
      sclk    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      owner   <= owner_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      sdata   <= sdata_d;
      sclk    <= sclk_d;
      latch   <= latch_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched with a frame-position reference model.
module tb_shift_sched;

  localparam int FRAME = 8 * 4 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;
  logic       gnt0, gnt1, sdata, sclk, latch, busy, owner;

  int checks = 0;
  int errors = 0;

  shift_sched #(.CLK_DIV(4), .NBITS(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .sdata (sdata),
    .sclk  (sclk),
    .latch (latch),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k is the cycle number within a frame (0 = idle,
  // 1..32 shifting, 33 latch strobe).
  int         m_k = 0;
  logic       m_pri = 1'b0;
  logic       m_owner = 1'b0;
  logic [7:0] m_byte = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k   = 0;
      m_pri = 1'b0;
    end else if (m_k == 0) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? m_pri : req1;
        m_pri   = !m_owner;
        m_byte  = m_owner ? data1 : data0;
        m_k     = 1;
      end
    end else if (m_k == FRAME) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  end

  // Per-cycle compare plus sclk-rise capture of sdata.
  logic prev_sclk = 1'b0;
  logic sq[$];

  always @(negedge clk) begin : cmp
    logic e_sd, e_sc;
    int   idx;
    e_sd = 1'b0;
    e_sc = 1'b0;
    if (m_k >= 1 && m_k <= FRAME - 1) begin
      idx  = m_k - 1;
      e_sd = m_byte[idx / 4];
      e_sc = (idx % 4) >= 2;
    end
    chk("busy", busy, m_k != 0);
    chk("gnt0", gnt0, m_k == 1 && !m_owner);
    chk("gnt1", gnt1, m_k == 1 && m_owner);
    chk("latch", latch, m_k == FRAME);
    chk("sdata", sdata, e_sd);
    chk("sclk", sclk, e_sc);
    chk("gnt_exclusive", gnt0 & gnt1, 0);
    if (m_k != 0) chk("owner", owner, m_owner);
    if (rst || gnt0 || gnt1) sq.delete();
    if (sclk && !prev_sclk) sq.push_back(sdata);
    if (latch) chk("latch_after_8_rises", sq.size(), 8);
    prev_sclk = sclk;
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_sdata"}, sdata, 0);
    chk({tag, "_sclk"}, sclk, 0);
    chk({tag, "_latch"}, latch, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  // Runs one frame from the cycle before capture; optionally raises req1
  // at frame cycle inj_at or asserts rst at frame cycle abort_at.
  task automatic run_frame(input logic who, input logic [7:0] b, input int inj_at,
                           input logic [7:0] inj_data, input int abort_at,
                           output int wait_n);
    int lat_at, idle_at, lat_cnt;
    logic [7:0] got;
    wait_n  = 0;
    lat_at  = -1;
    idle_at = -1;
    lat_cnt = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        wait_n = t;
        break;
      end
    end
    if (wait_n == 0) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    chk("gnt_who", gnt1, who);
    chk("owner_at_gnt", owner, who);
    if (who) req1 = 1'b0; else req0 = 1'b0;
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      if (n == inj_at) begin
        req1  = 1'b1;
        data1 = inj_data;
      end
      if (n == abort_at) begin
        #1 rst = 1'b1;
        #1 outputs_zero("abort");
        return;
      end
      if (latch) begin
        lat_cnt++;
        if (lat_at < 0) lat_at = n;
      end
      if (!busy) begin
        idle_at = n;
        break;
      end
    end
    chk("latch_cycle", lat_at, 33);
    chk("idle_cycle", idle_at, 34);
    chk("latch_count", lat_cnt, 1);
    chk("rise_count", sq.size(), 8);
    got = '0;
    for (int i = 0; i < 8 && i < sq.size(); i++) got[i] = sq[i];
    chk("frame_bits", got, b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    outputs_zero("reset");
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int w;
    do_reset();

    // Single request, A5 goes out as 1,0,1,0,0,1,0,1.
    data0 = 8'hA5;
    req0  = 1'b1;
    run_frame(1'b0, 8'hA5, -1, '0, -1, w);
    chk("a5_wait", w, 1);

    // Contention after reset: 0, then 1, then 0 again.
    do_reset();
    data0 = 8'h3C;
    data1 = 8'hC3;
    req0  = 1'b1;
    req1  = 1'b1;
    run_frame(1'b0, 8'h3C, -1, '0, -1, w);
    run_frame(1'b1, 8'hC3, -1, '0, -1, w);
    chk("b2b_wait", w, 1);
    data0 = 8'h81;
    data1 = 8'h7E;
    req0  = 1'b1;
    req1  = 1'b1;
    run_frame(1'b0, 8'h81, -1, '0, -1, w);
    run_frame(1'b1, 8'h7E, -1, '0, -1, w);

    // req1 raised mid-shift is held off until the frame returns to idle.
    data0 = 8'h5A;
    req0  = 1'b1;
    run_frame(1'b0, 8'h5A, 10, 8'h96, -1, w);
    run_frame(1'b1, 8'h96, -1, '0, -1, w);

    // Reset mid-frame, then a req1-only request is granted straight away.
    data0 = 8'hF0;
    req0  = 1'b1;
    run_frame(1'b0, 8'hF0, -1, '0, 15, w);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    data1 = 8'h2D;
    req1  = 1'b1;
    run_frame(1'b1, 8'h2D, -1, '0, -1, w);
    chk("post_reset_wait", w, 1);

    // Constant-data frames.
    data0 = 8'h00;
    req0  = 1'b1;
    run_frame(1'b0, 8'h00, -1, '0, -1, w);
    data1 = 8'hFF;
    req1  = 1'b1;
    run_frame(1'b1, 8'hFF, -1, '0, -1, w);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
